// File: rtl/rr_priority_arbiter.sv
// Registered N-requester arbiter, fixed-priority (MSB wins) or round-robin, presenting one grant
// at a time under a valid/ready handshake with no withdrawal while held.
module rr_priority_arbiter #(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx
);

  logic         valid_q;
  logic [N-1:0] onehot_q;
  logic [W-1:0] idx_q;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         win_found;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;
  logic [W:0]   scan;

  assign accept = valid_q & gnt_ready;

  // Round-robin arbitration on accept already uses the advanced pointer, so grants stay back-to-back.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && mode) begin
      ptr_d = (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    scan       = '0;
    if (!mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req[i]) begin
          win_found = 1'b1;
          win_idx   = W'(i);
        end
      end
    end else begin
      for (int unsigned off = 0; off < N; off++) begin
        scan = {1'b0, ptr_d} + (W + 1)'(off);
        if (scan >= (W + 1)'(N)) begin
          scan = scan - (W + 1)'(N);
        end
        if (!win_found && req[scan[W-1:0]]) begin
          win_found = 1'b1;
          win_idx   = scan[W-1:0];
        end
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      win_onehot[i] = win_found && (win_idx == W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      onehot_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
    end else begin
      if (!valid_q || gnt_ready) begin
        valid_q  <= win_found;
        onehot_q <= win_onehot;
        idx_q    <= win_idx;
      end
      ptr_q <= ptr_d;
    end
  end

  assign gnt_valid  = valid_q;
  assign gnt_onehot = onehot_q;
  assign gnt_idx    = idx_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench for rr_priority_arbiter: N=8 and N=5 instances share control inputs and are
// compared each cycle against a behavioural model of the grant/pointer rules.
module tb_rr_priority_arbiter;

  typedef struct {
    bit v;
    int idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b1;
  logic       gnt_ready = 1'b0;
  logic [7:0] req8 = '0;
  logic [4:0] req5 = '0;

  logic       v8, v5;
  logic [7:0] oh8;
  logic [4:0] oh5;
  logic [2:0] idx8, idx5;

  exp_t q8[$];
  exp_t q5[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  bit m8_v = 0, m5_v = 0;
  int m8_idx = 0, m5_idx = 0, m8_ptr = 0, m5_ptr = 0;

  rr_priority_arbiter #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .mode(mode), .gnt_ready(gnt_ready),
    .gnt_valid(v8), .gnt_onehot(oh8), .gnt_idx(idx8)
  );

  rr_priority_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .mode(mode), .gnt_ready(gnt_ready),
    .gnt_valid(v5), .gnt_onehot(oh5), .gnt_idx(idx5)
  );

  always #5 clk = ~clk;

  function automatic int arbitrate(input int n, input int rq, input bit m, input int ptr);
    if (!m) begin
      for (int i = n - 1; i >= 0; i--) if (rq[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) if (rq[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic model_step(input int n, input bit r, input bit m, input int rq, input bit rdy,
                            inout bit v, inout int idx, inout int ptr);
    int w;
    if (r) begin
      v = 0; idx = 0; ptr = 0;
    end else if (!v || rdy) begin
      if (v && m) ptr = (idx + 1) % n;
      w = arbitrate(n, rq, m, ptr);
      v   = (w >= 0);
      idx = (w >= 0) ? w : 0;
    end
  endtask

  task automatic drive(input bit r, input bit m, input logic [7:0] r8, input logic [4:0] r5,
                       input bit rdy);
    exp_t e;
    @(negedge clk);
    rst = r; mode = m; req8 = r8; req5 = r5; gnt_ready = rdy;
    model_step(8, r, m, int'(r8), rdy, m8_v, m8_idx, m8_ptr);
    model_step(5, r, m, int'(r5), rdy, m5_v, m5_idx, m5_ptr);
    e.v = m8_v; e.idx = m8_idx; q8.push_back(e);
    e.v = m5_v; e.idx = m5_idx; q5.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("n8_valid", 32'(v8), 32'(e.v));
        check("n8_idx", 32'(idx8), e.v ? e.idx : 0);
        check("n8_onehot", 32'(oh8), e.v ? (32'd1 << e.idx) : 0);
      end
      if (q5.size() > 0) begin
        e = q5.pop_front();
        check("n5_valid", 32'(v5), 32'(e.v));
        check("n5_idx", 32'(idx5), e.v ? e.idx : 0);
        check("n5_onehot", 32'(oh5), e.v ? (32'd1 << e.idx) : 0);
      end
    end
  end

  initial begin : stimulus
    logic [7:0] r8;
    logic [4:0] r5;
    // Reset with all requests active, then round-robin rotation through the wrap
    repeat (2) drive(1, 1, 8'hFF, 5'b10001, 1);
    repeat (10) drive(0, 1, 8'hFF, 5'b10001, 1);
    // Fixed priority, then no requests
    repeat (4) drive(0, 0, 8'b0010_0100, 5'b00110, 1);
    repeat (2) drive(0, 0, 8'h00, 5'b00000, 1);
    // Hold under backpressure, granted bit dropped during the hold, then accept
    drive(1, 1, 8'h00, 5'b00000, 0);
    repeat (5) drive(0, 1, 8'b0001_0010, 5'b10010, 0);
    repeat (2) drive(0, 1, 8'b0001_0000, 5'b10000, 0);
    drive(0, 1, 8'b0001_0000, 5'b10000, 1);
    repeat (2) drive(0, 1, 8'b0001_0010, 5'b10010, 0);
    // Reset mid-hold clears the pointer
    drive(1, 1, 8'h00, 5'b00000, 0);
    repeat (3) drive(0, 1, 8'b0000_1000, 5'b01000, 0);
    drive(1, 1, 8'b0000_1000, 5'b01000, 0);
    repeat (4) drive(0, 1, 8'hFF, 5'b11111, 1);
    // Mode switch with a held grant, pointer retained across modes
    repeat (3) drive(0, 0, 8'b0100_0110, 5'b01011, 1);
    drive(0, 1, 8'b0100_0110, 5'b01011, 0);
    repeat (4) drive(0, 1, 8'b0100_0110, 5'b01011, 1);
    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r8 = 8'($urandom) & 8'($urandom);
      r5 = 5'($urandom) & 5'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r8 = 8'($urandom);
        r5 = 5'($urandom);
      end
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), r8, r5,
            ($urandom_range(0, 2) != 0));
    end
    @(posedge clk);
    #2;
    check("queues_drained", 32'(q8.size() + q5.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
